// File: rtl/mult_pkg.sv
// mult_pkg: shared types, default sizes and product negate for the pipelined multiplier
package mult_pkg;
  typedef enum logic [1:0] {ACC_NONE, ACC_MADD, ACC_MSUB, ACC_MTHILO} acc_op_e;
  localparam int WIDTH_DEF = 32;
  localparam int SUB_W_DEF = 8;
  localparam int PROD_MAX = 128;
  function automatic logic [PROD_MAX-1:0] neg_prod(input logic [PROD_MAX-1:0] x);
    return -x;
  endfunction
endpackage

// File: rtl/mult_subprod.sv
// mult_subprod: combinational N*N array of SUB_W x SUB_W slice products, slot i*N+j holds a slice i * b slice j
module mult_subprod import mult_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SUB_W = SUB_W_DEF,
  localparam int N = WIDTH / SUB_W,
  localparam int SP = 2 * SUB_W
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [N*N*SP-1:0]   sub
);
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign sub[(i*N+j)*SP +: SP] = {SUB_W'(0), a[i*SUB_W +: SUB_W]} * {SUB_W'(0), b[j*SUB_W +: SUB_W]};
    end
  end
endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: two-stage valid/ready WIDTH x WIDTH multiplier (signed/unsigned) returning {hi,lo}
// Optional accumulator (MADD/MSUB/MTHILO) enabled by defining MULT_ACC_EN.
module mult_pipe import mult_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SUB_W = SUB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       acc_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int N = WIDTH / SUB_W;
  localparam int PW = 2 * WIDTH;
  localparam int SP = 2 * SUB_W;
  localparam int SW = N * N * SP;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic neg;
  logic [SW-1:0] sub_c, s1_sub;
  logic s1_valid, s1_neg, s2_valid;
  logic s1_adv, s2_adv, in_take, s2_load;
  logic [PW-1:0] sum, prod, result;
  logic [PROD_MAX-1:0] neg_full;
  assign mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b = (signed_op && b[WIDTH-1]) ? -b : b;
  assign neg = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;
  assign in_take = s1_adv && in_valid;
  assign s2_load = s2_adv && s1_valid && !flush;
  mult_subprod #(.WIDTH(WIDTH), .SUB_W(SUB_W)) u_subprod (.a(mag_a), .b(mag_b), .sub(sub_c));
  // shift each registered slice product into place and sum in 2*WIDTH bits
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sum = sum + (PW'(s1_sub[(i*N+j)*SP +: SP]) << (SUB_W*(i+j)));
  end
  assign neg_full = neg_prod(PROD_MAX'(sum));
  assign prod = s1_neg ? neg_full[PW-1:0] : sum;
`ifdef MULT_ACC_EN
  acc_op_e s1_op;
  logic [PW-1:0] s1_ab, acc, acc_nx;
  // next accumulator value for the op leaving stage 1
  always_comb begin
    acc_nx = s1_op == ACC_MADD ? acc + prod :
             s1_op == ACC_MSUB ? acc - prod :
             s1_op == ACC_MTHILO ? s1_ab : acc;
    result = s1_op == ACC_NONE ? prod : acc_nx;
  end
  // op and raw operands travel with stage 1; acc only moves when an op really loads stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_op <= ACC_NONE;
      s1_ab <= '0;
      acc <= '0;
    end else begin
      if (in_take) begin
        s1_op <= acc_op_e'(acc_op);
        s1_ab <= {a, b};
      end
      if (s2_load) acc <= acc_nx;
    end
  end
`else
  logic unused_acc_op;
  assign unused_acc_op = ^acc_op;
  assign result = prod;
`endif
  // pipeline valids and data; flush kills valids only, stalled stages hold
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_neg <= 1'b0;
      s1_sub <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s1_adv) s1_valid <= in_valid;
        if (s2_adv) s2_valid <= s1_valid;
      end
      if (in_take) begin
        s1_neg <= neg;
        s1_sub <= sub_c;
      end
      if (s2_load) {hi, lo} <= result;
    end
  end
endmodule
